// File: rtl/ram_sp_param_if.sv
// Access bus for the parametrised single-port data RAM.
// The master drives address/data/strobes; the RAM (slave) returns read data and status.
interface ram_sp_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]   Addr;
    logic                Write_En;
    logic [DATA_W/8-1:0] Byte_En;
    logic [DATA_W-1:0]   D;
    logic                Read_En;
    logic                Clear_Req;
    logic [DATA_W-1:0]   O;
    logic                Rd_Valid;
    logic                Ready;

    modport master (
        output Addr, Write_En, Byte_En, D, Read_En, Clear_Req,
        input  O, Rd_Valid, Ready
    );

    modport slave (
        input  Addr, Write_En, Byte_En, D, Read_En, Clear_Req,
        output O, Rd_Valid, Ready
    );
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte lanes, registered read port
// and a clear sequencer that fills the array with INIT_VAL after reset or on request.
module ram_sp_param #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter bit                RD_MODE  = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_sp_param_if.slave  bus
);
    localparam int              LANES    = DATA_W / 8;
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              access_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LANES-1:0]  wr_lanes;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;

    // The extra counter bit keeps the terminal compare free of wrap-around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                cnt <= cnt + CNT_ONE;
            end else if (bus.Clear_Req) begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (cnt == LAST_CNT) next_state = READY;
            READY:   if (bus.Clear_Req)   next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // During the sweep the bus is locked out and the counter owns the write port.
    always_comb begin
        access_ok = (state == READY);
        bus.Ready = access_ok;
        if (access_ok) begin
            wr_addr  = bus.Addr;
            wr_data  = bus.D;
            wr_lanes = bus.Write_En ? bus.Byte_En : '0;
        end else begin
            wr_addr  = cnt[ADDR_W-1:0];
            wr_data  = INIT_VAL;
            wr_lanes = '1;
        end
    end

    always_comb begin
        old_word    = mem[bus.Addr];
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (wr_lanes[i]) merged_word[8*i +: 8] = bus.D[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lanes[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // Write-first returns the merged word; read-first returns the pre-write word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.O        <= '0;
            bus.Rd_Valid <= 1'b0;
        end else if (access_ok && bus.Read_En) begin
            bus.O        <= RD_MODE ? old_word : merged_word;
            bus.Rd_Valid <= 1'b1;
        end else begin
            bus.Rd_Valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: a write-first and a read-first 256x16 instance
// driven in lockstep, plus a 16x32 instance for the narrow-depth/wide-word case.
module tb_ram_sp_param;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_n_c = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n;
    int   bad;

    always #5 clk = ~clk;

    ram_sp_param_if #(.DATA_W(16), .ADDR_W(8)) bus_a ();
    ram_sp_param_if #(.DATA_W(16), .ADDR_W(8)) bus_b ();
    ram_sp_param_if #(.DATA_W(32), .ADDR_W(4)) bus_c ();

    ram_sp_param #(.DATA_W(16), .ADDR_W(8), .INIT_VAL(16'h0000), .RD_MODE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    ram_sp_param #(.DATA_W(16), .ADDR_W(8), .INIT_VAL(16'h0000), .RD_MODE(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );
    ram_sp_param #(.DATA_W(32), .ADDR_W(4), .INIT_VAL(32'hDEADBEEF), .RD_MODE(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .bus(bus_c)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] addr, input logic we, input logic [1:0] be,
                                  input logic [15:0] d, input logic re, input logic clr);
        bus_a.Addr = addr; bus_a.Write_En = we; bus_a.Byte_En = be;
        bus_a.D = d; bus_a.Read_En = re; bus_a.Clear_Req = clr;
        bus_b.Addr = addr; bus_b.Write_En = we; bus_b.Byte_En = be;
        bus_b.D = d; bus_b.Read_En = re; bus_b.Clear_Req = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus_c(input logic [3:0] addr, input logic we, input logic [3:0] be,
                                    input logic [31:0] d, input logic re, input logic clr);
        bus_c.Addr = addr; bus_c.Write_En = we; bus_c.Byte_En = be;
        bus_c.D = d; bus_c.Read_En = re; bus_c.Clear_Req = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.Addr = '0; bus_a.Write_En = 1'b0; bus_a.Byte_En = '0;
        bus_a.D = '0; bus_a.Read_En = 1'b0; bus_a.Clear_Req = 1'b0;
        bus_b.Addr = '0; bus_b.Write_En = 1'b0; bus_b.Byte_En = '0;
        bus_b.D = '0; bus_b.Read_En = 1'b0; bus_b.Clear_Req = 1'b0;
        bus_c.Addr = '0; bus_c.Write_En = 1'b0; bus_c.Byte_En = '0;
        bus_c.D = '0; bus_c.Read_En = 1'b0; bus_c.Clear_Req = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ready", {31'd0, bus_a.Ready}, 32'd0);
        check_output("reset_o", {16'd0, bus_a.O}, 32'd0);
        check_output("reset_valid", {31'd0, bus_a.Rd_Valid}, 32'd0);

        // Initial sweep: Ready stays low for exactly 256 edges.
        rst_n = 1'b1;
        n = 0;
        while (!bus_a.Ready && n < 1000) begin
            apply_stimulus(8'h00, 1'b1, 2'b11, 16'hFFFF, 1'b1, 1'b0);
            n++;
        end
        check_output("init_sweep_len", n, 32'd256);
        check_output("init_ready_b", {31'd0, bus_b.Ready}, 32'd1);

        apply_stimulus(8'h00, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("init_rd00_o", {16'd0, bus_a.O}, 32'h0000);
        check_output("init_rd00_valid", {31'd0, bus_a.Rd_Valid}, 32'd1);
        apply_stimulus(8'h7F, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("init_rd7f_o", {16'd0, bus_a.O}, 32'h0000);
        apply_stimulus(8'hFF, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("init_rdff_o", {16'd0, bus_a.O}, 32'h0000);
        check_output("init_rdff_valid", {31'd0, bus_a.Rd_Valid}, 32'd1);

        // Full-word writes then back-to-back reads.
        apply_stimulus(8'h12, 1'b1, 2'b11, 16'h1234, 1'b0, 1'b0);
        check_output("wr_valid_low", {31'd0, bus_a.Rd_Valid}, 32'd0);
        apply_stimulus(8'h34, 1'b1, 2'b11, 16'h3456, 1'b0, 1'b0);
        apply_stimulus(8'hF0, 1'b1, 2'b11, 16'hF012, 1'b0, 1'b0);
        apply_stimulus(8'h12, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("rd12", {16'd0, bus_a.O}, 32'h1234);
        check_output("rd12_valid", {31'd0, bus_a.Rd_Valid}, 32'd1);
        apply_stimulus(8'h34, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("rd34", {16'd0, bus_a.O}, 32'h3456);
        check_output("rd34_valid", {31'd0, bus_a.Rd_Valid}, 32'd1);
        apply_stimulus(8'hF0, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("rdf0", {16'd0, bus_a.O}, 32'hF012);
        check_output("rdf0_b", {16'd0, bus_b.O}, 32'hF012);

        // Byte lanes.
        apply_stimulus(8'h40, 1'b1, 2'b11, 16'hAAAA, 1'b0, 1'b0);
        apply_stimulus(8'h40, 1'b1, 2'b01, 16'h5555, 1'b0, 1'b0);
        apply_stimulus(8'h40, 1'b1, 2'b00, 16'hFFFF, 1'b0, 1'b0);
        apply_stimulus(8'h40, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("lane_merge", {16'd0, bus_a.O}, 32'hAA55);
        apply_stimulus(8'h12, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        check_output("hold_o", {16'd0, bus_a.O}, 32'hAA55);
        check_output("hold_valid", {31'd0, bus_a.Rd_Valid}, 32'd0);

        // Read during write, full word and partial lane.
        apply_stimulus(8'h56, 1'b1, 2'b11, 16'h1111, 1'b0, 1'b0);
        apply_stimulus(8'h56, 1'b1, 2'b11, 16'h2222, 1'b1, 1'b0);
        check_output("rdw_first_a", {16'd0, bus_a.O}, 32'h2222);
        check_output("rdw_first_b", {16'd0, bus_b.O}, 32'h1111);
        apply_stimulus(8'h56, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("rdw_after_a", {16'd0, bus_a.O}, 32'h2222);
        check_output("rdw_after_b", {16'd0, bus_b.O}, 32'h2222);
        apply_stimulus(8'h56, 1'b1, 2'b10, 16'h3344, 1'b1, 1'b0);
        check_output("rdw_lane_a", {16'd0, bus_a.O}, 32'h3322);
        check_output("rdw_lane_b", {16'd0, bus_b.O}, 32'h2222);

        // Clear request: same-cycle access completes, then the bus is locked out.
        apply_stimulus(8'h56, 1'b1, 2'b11, 16'h9999, 1'b1, 1'b1);
        check_output("clr_ready_drop", {31'd0, bus_a.Ready}, 32'd0);
        check_output("clr_cycle_o_a", {16'd0, bus_a.O}, 32'h9999);
        check_output("clr_cycle_o_b", {16'd0, bus_b.O}, 32'h3322);
        check_output("clr_cycle_valid", {31'd0, bus_a.Rd_Valid}, 32'd1);
        n = 0;
        bad = 0;
        while (!bus_a.Ready && n < 1000) begin
            apply_stimulus(8'h12, 1'b1, 2'b11, 16'hBEEF, 1'b1, 1'b0);
            n++;
            if (bus_a.Rd_Valid || bus_b.Rd_Valid || bus_a.O !== 16'h9999) bad++;
        end
        check_output("clr_sweep_len", n, 32'd256);
        check_output("clr_lockout", bad, 32'd0);
        apply_stimulus(8'h12, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("clr_rd12", {16'd0, bus_a.O}, 32'h0000);
        apply_stimulus(8'h56, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("clr_rd56_b", {16'd0, bus_b.O}, 32'h0000);

        // Reset in the middle of a sweep restarts it from address 0.
        apply_stimulus(8'h12, 1'b1, 2'b11, 16'hABCD, 1'b0, 1'b0);
        apply_stimulus(8'h12, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        check_output("pre_rst_o", {16'd0, bus_a.O}, 32'hABCD);
        apply_stimulus(8'h00, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) apply_stimulus(8'h00, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_o", {16'd0, bus_a.O}, 32'h0000);
        check_output("midrst_ready", {31'd0, bus_a.Ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!bus_a.Ready && n < 1000) begin
            apply_stimulus(8'h00, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
            n++;
        end
        check_output("midrst_sweep_len", n, 32'd256);

        // 16x32 instance: short sweep, non-zero fill, four-lane merge.
        check_output("c_reset_ready", {31'd0, bus_c.Ready}, 32'd0);
        rst_n_c = 1'b1;
        n = 0;
        while (!bus_c.Ready && n < 1000) begin
            apply_stimulus_c(4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        check_output("c_sweep_len", n, 32'd16);
        apply_stimulus_c(4'h5, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        check_output("c_init_rd5", bus_c.O, 32'hDEADBEEF);
        apply_stimulus_c(4'h3, 1'b1, 4'hF, 32'h11223344, 1'b0, 1'b0);
        apply_stimulus_c(4'h3, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, 1'b0);
        apply_stimulus_c(4'h3, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        check_output("c_merge", bus_c.O, 32'h11BB33DD);
        apply_stimulus_c(4'h3, 1'b1, 4'hA, 32'h55667788, 1'b1, 1'b0);
        check_output("c_rdw_merge", bus_c.O, 32'h55BB77DD);
        apply_stimulus_c(4'hF, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        check_output("c_init_rdf", bus_c.O, 32'hDEADBEEF);
        check_output("c_valid", {31'd0, bus_c.Rd_Valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
